// File: rtl/ss_framer.sv
// rtl/ss_framer.sv - frame-length-bounded sample buffer feeding an AXI-Stream FIR input
module ss_framer #(
  parameter int pDATA_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   start,
  input  logic [31:0]            data_length,
  input  logic                   in_valid,
  input  logic [pDATA_WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic                   ss_tvalid,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tlast,
  input  logic                   ss_tready,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            sent_count
);

  // Pointer width; occupancy carries one extra bit so full and empty differ.
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            len_q, len_d;
  logic [31:0]            acc_q, acc_d;
  logic [31:0]            sent_q, sent_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            cnt_q, cnt_d;
  logic [pDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [pDATA_WIDTH-1:0] mem_d [FIFO_DEPTH];

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  // Handshake qualifiers and stream outputs, all decoded from registered state.
  always_comb begin
    fifo_full  = (cnt_q == FULL_CNT);
    fifo_empty = (cnt_q == '0);
    in_ready   = (state_q == S_RUN) && !fifo_full && (acc_q < len_q);
    ss_tvalid  = (state_q == S_RUN) && !fifo_empty;
    ss_tdata   = ss_tvalid ? mem_q[rd_ptr_q] : '0;
    ss_tlast   = ss_tvalid && (sent_q == (len_q - 32'd1));
    push       = in_valid && in_ready;
    pop        = ss_tvalid && ss_tready;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    sent_count = sent_q;
  end

  // Next-state for the frame FSM, counters and FIFO storage.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    acc_d    = acc_q;
    sent_d   = sent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d    = data_length;
          acc_d    = '0;
          sent_d   = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
          state_d  = (data_length == 32'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (push) begin
          mem_d[wr_ptr_q] = in_data;
          wr_ptr_d        = wr_ptr_q + AW'(1);
          acc_d           = acc_q + 32'd1;
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          sent_d   = sent_q + 32'd1;
          if (ss_tlast) begin
            state_d = S_DONE;
          end
        end
        case ({push, pop})
          2'b10:   cnt_d = cnt_q + (AW+1)'(1);
          2'b01:   cnt_d = cnt_q - (AW+1)'(1);
          default: cnt_d = cnt_q;
        endcase
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register everything; reset wins over start and any handshake.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      acc_q    <= '0;
      sent_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      acc_q    <= acc_d;
      sent_q   <= sent_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_ss_framer.sv
// tb/tb_ss_framer.sv - self-checking bench for ss_framer against a queue-based frame model
module tb_ss_framer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          axis_clk = 1'b0;
  logic          axis_rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   data_length = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          ss_tvalid;
  logic [DW-1:0] ss_tdata;
  logic          ss_tlast;
  logic          ss_tready = 1'b0;
  logic          busy;
  logic          done;
  logic [31:0]   sent_count;

  ss_framer #(.pDATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .axis_clk   (axis_clk),
    .axis_rst   (axis_rst),
    .start      (start),
    .data_length(data_length),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ss_tvalid  (ss_tvalid),
    .ss_tdata   (ss_tdata),
    .ss_tlast   (ss_tlast),
    .ss_tready  (ss_tready),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count)
  );

  always #5 axis_clk = ~axis_clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame model: mode 0 idle, 1 run, 2 done; buffer is a plain queue.
  int          m_mode = 0;
  logic [31:0] m_q[$];
  int unsigned m_acc = 0;
  int unsigned m_sent = 0;
  int unsigned m_len = 0;
  bit          chk_en = 0;

  // Stimulus controls and observation logs.
  int          vprob = 0;
  int          rprob = 0;
  int          fid = 0;
  bit          tri_mode = 0;
  int unsigned src_idx = 0;
  bit          hs_in = 0;
  logic [31:0] beat_d[$];
  bit          beat_l[$];
  int          beat_c[$];
  int          done_c[$];
  int          cyc = 0;
  bit          tvalid_seen = 0;
  int          acc_seen = 0;
  int          max_occ = 0;

  function automatic logic [31:0] gen(input int unsigned i);
    int v;
    if (tri_mode) begin
      v = (i < 300) ? int'(i) - 150 : 450 - int'(i);
      return v;
    end
    return (fid << 16) | i;
  endfunction

  // Compare DUT against the model each cycle, log handshakes, then advance the model.
  always @(negedge axis_clk) begin : cmp
    logic        e_ready, e_valid, e_last;
    logic [31:0] e_data;
    bit          pop, push;
    cyc++;
    e_ready = (m_mode == 1) && (m_q.size() < DEPTH) && (m_acc < m_len);
    e_valid = (m_mode == 1) && (m_q.size() > 0);
    e_data  = e_valid ? m_q[0] : 32'd0;
    e_last  = e_valid && (m_sent == m_len - 1);
    if (chk_en) begin
      check("cyc_in_ready",   in_ready,   e_ready);
      check("cyc_ss_tvalid",  ss_tvalid,  e_valid);
      check("cyc_ss_tdata",   ss_tdata,   e_data);
      check("cyc_ss_tlast",   ss_tlast,   e_last);
      check("cyc_busy",       busy,       m_mode != 0);
      check("cyc_done",       done,       m_mode == 2);
      check("cyc_sent_count", sent_count, m_sent);
    end
    hs_in = in_valid && in_ready;
    if (in_valid && in_ready) acc_seen++;
    if (ss_tvalid) tvalid_seen = 1;
    if (ss_tvalid && ss_tready) begin
      beat_d.push_back(ss_tdata);
      beat_l.push_back(ss_tlast);
      beat_c.push_back(cyc);
    end
    if (done) done_c.push_back(cyc);
    if (acc_seen - beat_d.size() > max_occ) max_occ = acc_seen - beat_d.size();
    if (axis_rst) begin
      m_mode = 0; m_q.delete(); m_acc = 0; m_sent = 0; m_len = 0;
      chk_en = 1;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_len = data_length; m_acc = 0; m_sent = 0; m_q.delete();
          m_mode = (data_length == 0) ? 2 : 1;
        end
        1: begin
          pop  = e_valid && ss_tready;
          push = e_ready && in_valid;
          if (pop) begin
            void'(m_q.pop_front());
            m_sent++;
          end
          if (push) begin
            m_q.push_back(in_data);
            m_acc++;
          end
          if (pop && e_last) m_mode = 2;
        end
        default: m_mode = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge axis_clk);
    #1;
    start    = 1'b0;
    axis_rst = 1'b0;
    if (hs_in) src_idx++;
    in_valid  = ($urandom_range(0, 99) < vprob);
    ss_tready = ($urandom_range(0, 99) < rprob);
    in_data   = gen(src_idx);
  endtask

  task automatic clear_logs();
    beat_d.delete(); beat_l.delete(); beat_c.delete(); done_c.delete();
    tvalid_seen = 0; acc_seen = 0; max_occ = 0;
  endtask

  task automatic begin_frame(input int f, input int unsigned len);
    clear_logs();
    fid = f;
    src_idx = 0;
    in_data = gen(0);
    start = 1'b1;
    data_length = len;
    tick();
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_c.size() == 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, done_c.size() != 0, 1);
  endtask

  task automatic check_frame(input string name, input int n);
    int lasts = 0;
    check({name, "_beats"}, beat_d.size(), n);
    if (beat_d.size() == n) begin
      for (int i = 0; i < n; i++) begin
        if (beat_d[i] !== gen(i)) check({name, "_data"}, beat_d[i], gen(i));
        if (beat_l[i]) lasts++;
      end
      check({name, "_last_pos"}, beat_l[n-1], 1);
    end
    check({name, "_last_cnt"}, lasts, 1);
    check({name, "_done_cnt"}, done_c.size(), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    axis_rst = 1'b1;
    repeat (3) @(posedge axis_clk);
    #1;
    check("rst_in_ready",   in_ready,   0);
    check("rst_ss_tvalid",  ss_tvalid,  0);
    check("rst_ss_tdata",   ss_tdata,   0);
    check("rst_ss_tlast",   ss_tlast,   0);
    check("rst_busy",       busy,       0);
    check("rst_done",       done,       0);
    check("rst_sent_count", sent_count, 0);
    tick();

    // Length 5, both sides always ready.
    vprob = 100; rprob = 100;
    begin_frame(1, 5);
    check("f5_in_ready_after_start", in_ready, 1);
    wait_done(50, "f5_done_timeout");
    tick(); tick();
    check_frame("f5", 5);
    if (beat_d.size() == 5) begin
      check("f5_beat0_literal", beat_d[0], 32'h0001_0000);
      check("f5_beat4_literal", beat_d[4], 32'h0001_0004);
      check("f5_done_timing", done_c[0], beat_c[4] + 1);
    end
    check("f5_sent_hold", sent_count, 5);
    check("f5_idle_busy", busy, 0);

    // Length 8 with downstream stalled for 10 cycles.
    vprob = 100; rprob = 0;
    begin_frame(2, 8);
    repeat (10) tick();
    check("f8_stall_in_ready", in_ready, 0);
    check("f8_stall_accepts", src_idx, 4);
    check("f8_stall_tvalid", ss_tvalid, 1);
    check("f8_stall_tdata", ss_tdata, 32'h0002_0000);
    check("f8_stall_tlast", ss_tlast, 0);
    rprob = 100;
    wait_done(100, "f8_done_timeout");
    tick();
    check_frame("f8", 8);

    // Zero-length frame goes straight to done.
    vprob = 100; rprob = 100;
    begin_frame(3, 0);
    check("f0_done", done, 1);
    check("f0_busy", busy, 1);
    check("f0_sent", sent_count, 0);
    tick();
    check("f0_done_clear", done, 0);
    check("f0_busy_clear", busy, 0);
    repeat (3) tick();
    check("f0_no_tvalid", tvalid_seen, 0);

    // Reset mid-frame after 3 beats, then a full 600-beat frame.
    begin_frame(4, 600);
    n = 0;
    while (beat_d.size() < 3 && n < 50) begin tick(); n++; end
    check("f600_reach3", beat_d.size() >= 3, 1);
    axis_rst = 1'b1;
    tick();
    check("f600_rst_tvalid", ss_tvalid, 0);
    check("f600_rst_in_ready", in_ready, 0);
    check("f600_rst_sent", sent_count, 0);
    check("f600_rst_busy", busy, 0);
    begin_frame(4, 600);
    wait_done(2000, "f600_done_timeout");
    tick();
    check_frame("f600", 600);

    // Start re-pulsed mid-frame must be ignored.
    begin_frame(5, 11);
    n = 0;
    while (beat_d.size() < 2 && n < 50) begin tick(); n++; end
    start = 1'b1; data_length = 3;
    wait_done(100, "f11_done_timeout");
    repeat (5) tick();
    check_frame("f11", 11);
    check("f11_sent", sent_count, 11);

    // Random handshakes with a triangular sample ramp.
    tri_mode = 1; vprob = 50; rprob = 50;
    begin_frame(6, 600);
    wait_done(10000, "tri_done_timeout");
    tick();
    check_frame("tri", 600);
    if (beat_d.size() == 600) begin
      check("tri_first_literal", beat_d[0], 32'hFFFF_FF6A);
      check("tri_last_literal", beat_d[599], 32'hFFFF_FF6B);
    end
    check("tri_max_occ", max_occ <= DEPTH, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ss_framer.md
SS_FRAMER -- requirements
Module: ss_framer

Interface
REQ-001: Parameter pDATA_WIDTH, default 32, width of sample data.
REQ-002: Parameter FIFO_DEPTH, default 4, entries in the internal sample buffer (power of two).
REQ-003: axis_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004: axis_rst  input  1  reset, synchronous, active-high.
REQ-005: start  input  1  single-cycle pulse; begins one frame.
REQ-006: data_length  input  32  samples per frame; sampled only on an accepted start.
REQ-007: in_valid  input  1  upstream sample valid.
REQ-008: in_data  input  pDATA_WIDTH  upstream sample (signed, passed unmodified).
REQ-009: in_ready  output  1  block accepts in_data this cycle.
REQ-010: ss_tvalid  output  1  AXI-Stream valid toward the FIR stream input.
REQ-011: ss_tdata  output  pDATA_WIDTH  AXI-Stream data toward the FIR.
REQ-012: ss_tlast  output  1  marks the final sample of the frame.
REQ-013: ss_tready  input  1  FIR stream-input ready.
REQ-014: busy  output  1  high whenever state is not IDLE.
REQ-015: done  output  1  one-cycle pulse at frame completion.
REQ-016: sent_count  output  32  samples delivered on ss_* in current/last frame.

Function
REQ-017: States IDLE, RUN, DONE; encoding free.
REQ-018: IDLE + start + data_length!=0 -> RUN; latch length, clear accepted/sent counters and FIFO.
REQ-019: IDLE + start + data_length==0 -> DONE directly; no ss_tvalid ever asserted.
REQ-020: start in RUN or DONE is ignored; latched length unchanged.
REQ-021: RUN: in_ready = FIFO not full AND accepted_count < latched length; IDLE/DONE: in_ready=0.
REQ-022: Push when in_valid && in_ready; accepted_count increments by 1.
REQ-023: ss_tvalid = FIFO not empty (RUN only); ss_tdata = FIFO head, registered storage, no combinational path from in_data.
REQ-024: Latency: sample pushed into empty FIFO at edge N drives ss_tdata/ss_tvalid after edge N (visible cycle N+1).
REQ-025: ss_tlast = ss_tvalid && sent_count == latched length-1; never high otherwise.
REQ-026: Pop when ss_tvalid && ss_tready; sent_count increments by 1.
REQ-027: While ss_tvalid && !ss_tready, ss_tdata and ss_tlast hold stable.
REQ-028: Push and pop same cycle: occupancy unchanged, both succeed; permitted at any occupancy where in_ready=1.
REQ-029: Read/write pointers wrap modulo FIFO_DEPTH; occupancy tracked with log2(FIFO_DEPTH)+1 bits to distinguish full from empty.
REQ-030: Samples leave in acceptance order; no drop, no duplication.
REQ-031: Pop with ss_tlast -> DONE; DONE lasts exactly one cycle with done=1, then IDLE.
REQ-032: Upstream samples offered after length reached are not accepted (in_ready=0).
REQ-033: sent_count holds its final value in IDLE until next accepted start.

Reset
REQ-034: axis_rst=1 at a rising edge, in any state including mid-frame: state IDLE, FIFO emptied, counters 0, latched length 0.
REQ-035: Outputs after reset: in_ready=0, ss_tvalid=0, ss_tdata=0, ss_tlast=0, busy=0, done=0, sent_count=0.
REQ-036: axis_rst has priority over start and all handshakes in the same cycle.

Verification
REQ-037: length=5, in_valid=1 continuous, ss_tready=1 -> 5 beats in order, ss_tlast only on beat 5, done one cycle after beat 5, sent_count=5.
REQ-038: length=8, in_valid=1, ss_tready=0 for 10 cycles -> in_ready drops after 4 accepts, ss_tdata holds sample 0; release -> samples 0..7 in order, tlast on 8th.
REQ-039: start with data_length=0 -> done=1 on next cycle, busy 1 for that cycle, ss_tvalid never 1.
REQ-040: length=600, axis_rst pulsed after 3 beats -> next cycle ss_tvalid=0, in_ready=0, sent_count=0; new start delivers full 600-beat frame, tlast on beat 600.
REQ-041: start pulsed again at beat 2 of a length=11 frame -> ignored; frame ends after 11 beats, single done pulse.
REQ-042: random in_valid/ss_tready (50%), length=600 triangular samples -> output sequence equals input sequence, occupancy never exceeds 4, exactly one tlast.
